// File: rtl/fsm1s_pkg.sv
// Shared types for the two-state toggle tracker.
package fsm1s_pkg;

  // A = 0 (out low), B = 1 (out high)
  typedef enum logic {
    ST_A = 1'b0,
    ST_B = 1'b1
  } fsm1s_state_t;

  localparam fsm1s_state_t FSM1S_RESET_STATE = ST_B;

endpackage : fsm1s_pkg

// File: rtl/fsm1s_top.sv
// Two-state Moore toggle tracker: in=1 holds, in=0 toggles, out high in B.
// The output is decoded only from the state register, so in has no
// combinational path to out.
module fsm1s_top
  import fsm1s_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  fsm1s_state_t state;
  fsm1s_state_t state_next;

  // State register; reset is sampled only on the rising edge and wins over in
  always_ff @(posedge clk) begin
    if (reset) state <= FSM1S_RESET_STATE;
    else       state <= state_next;
  end

  // Next-state: hold on in=1, toggle on in=0; unknown encodings recover to reset state
  always_comb begin
    state_next = FSM1S_RESET_STATE;
    case (state)
      ST_A:    state_next = in ? ST_A : ST_B;
      ST_B:    state_next = in ? ST_B : ST_A;
      default: state_next = FSM1S_RESET_STATE;
    endcase
  end

  assign out = (state == ST_B);

endmodule : fsm1s_top

// File: tb/tb_fsm1s_top.sv
// Bench for fsm1s_top: directed reset/toggle scenarios plus random traffic,
// checked on both clock edges against a toggle-count parity model.
module tb_fsm1s_top;

  logic clk;
  logic reset;
  logic in;
  logic out;

  int vectors   = 0;
  int miscompares = 0;

  // Model: number of in=0 edges since the last reset edge; out = even count.
  int  toggles   = 0;
  bit  model_vld = 0;

  fsm1s_top dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic exp_out();
    return (toggles % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: out=%b expected=%b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, then check after the rising and falling edges.
  task automatic step(input logic r, input logic i, input string tag);
    reset = r;
    in    = i;
    @(posedge clk);
    if (r) begin
      toggles   = 0;
      model_vld = 1;
    end else if (!i) begin
      toggles++;
    end
    #1;
    if (model_vld) chk({tag, "_pos"}, out, exp_out());
    @(negedge clk);
    #1;
    if (model_vld) chk({tag, "_neg"}, out, exp_out());
  endtask

  initial begin
    reset = 1'b1;
    in    = 1'b1;

    // 1: reset 2 cycles, toggle to A, then hold
    step(1, 1, "t1_rst0");
    step(1, 1, "t1_rst1");
    step(0, 0, "t1_tog");
    step(0, 1, "t1_hold0");
    step(0, 1, "t1_hold1");

    // 2: from A, toggle three times then hold in B
    step(1, 1, "t2_rst");
    step(0, 0, "t2_toA");
    step(0, 0, "t2_tog0");
    step(0, 0, "t2_tog1");
    step(0, 0, "t2_tog2");
    step(0, 1, "t2_hold0");
    step(0, 1, "t2_hold1");

    // 3: reset raised mid-cycle in A must not act before the edge
    step(1, 1, "t3_rst");
    step(0, 0, "t3_toA");
    reset = 1'b1;
    in    = 1'b0;
    #2;
    chk("t3_sync_rst", out, 1'b0);
    in = 1'b1;
    #1;
    chk("t3_in_nocomb", out, 1'b0);
    step(1, 0, "t3_rst_e0");
    step(1, 0, "t3_rst_e1");

    // 4: reset and in=0 together from B: reset wins
    step(1, 1, "t4_rst");
    step(1, 0, "t4_rst_tog");
    step(0, 1, "t4_hold");

    // 5: random traffic, reset roughly 1 in 8
    for (int k = 0; k < 100; k++) begin
      step(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1);
  end

endmodule : tb_fsm1s_top
